// File: rtl/proc_pkg.sv
// Shared types, instruction field positions and opcode classification
// helpers for the fetch/decode/issue front end.
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_AND   = 4'b0011,
    OP_OR    = 4'b0100,
    OP_XOR   = 4'b0101,
    OP_INC   = 4'b0110,
    OP_DEC   = 4'b0111,
    OP_NOT   = 4'b1000,
    OP_SHL   = 4'b1001,
    OP_SHR   = 4'b1010,
    OP_ASR   = 4'b1011,
    OP_ROR   = 4'b1100,
    OP_ROL   = 4'b1101,
    OP_LOAD  = 4'b1110,
    OP_STORE = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_HALTED
  } fiu_state_t;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int DEST_MSB   = 11;
  localparam int DEST_LSB   = 9;
  localparam int SRCA_MSB   = 8;
  localparam int SRCA_LSB   = 6;
  localparam int SRCB_MSB   = 5;
  localparam int SRCB_LSB   = 3;
  localparam int SDA_MSB    = 3;
  localparam int SDA_LSB    = 0;

  // Everything except NOP and STORE produces a register result.
  function automatic logic writes_reg(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_STORE);
  endfunction

  function automatic logic reads_a(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_ROL)) || (op == OP_STORE);
  endfunction

  function automatic logic reads_b(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/fetch_issue_unit_if.sv
// Instruction issue interface between the front end (master) and the
// execution unit (slave).
interface fetch_issue_unit_if;
  logic [3:0] opcode;
  logic [2:0] dest_reg;
  logic [2:0] opAAdr;
  logic [2:0] opBAdr;
  logic [3:0] storeDataAdr;
  logic       issue_valid;
  logic       eu_ready;

  modport master (
    output opcode, dest_reg, opAAdr, opBAdr, storeDataAdr, issue_valid,
    input  eu_ready
  );

  modport slave (
    input  opcode, dest_reg, opAAdr, opBAdr, storeDataAdr, issue_valid,
    output eu_ready
  );
endinterface

// File: rtl/fetch_issue_unit_hazard_tracker.sv
// Read-after-write hazard window: remembers the destination of the last
// register-writing transfer and holds dependents for HAZARD_CYCLES cycles.
module hazard_tracker #(
  parameter int HAZARD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       transfer,
  input  logic       writes,
  input  logic [2:0] dest,
  input  logic       reads_a,
  input  logic       reads_b,
  input  logic [2:0] src_a,
  input  logic [2:0] src_b,
  output logic       stall
);

  localparam int CNT_W = (HAZARD_CYCLES < 1) ? 1 : $clog2(HAZARD_CYCLES + 1);

  logic [CNT_W-1:0] count;
  logic [2:0]       last_dest;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      count     <= '0;
      last_dest <= '0;
    end else if (transfer) begin
      if (writes) begin
        count     <= CNT_W'(HAZARD_CYCLES);
        last_dest <= dest;
      end else begin
        count <= '0;
      end
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign stall = (count != '0) &&
                 ((reads_a && (src_a == last_dest)) ||
                  (reads_b && (src_b == last_dest)));

endmodule

// File: rtl/fetch_issue_unit.sv
// Instruction fetch/decode/issue front end with RAW hazard stall.
// Optional FIU_PERF_CNT_EN adds issued_count / stall_count outputs.
module fetch_issue_unit
  import proc_pkg::*;
#(
  parameter int          PC_W          = 8,
  parameter int          HAZARD_CYCLES = 3,
  parameter logic [15:0] HALT_WORD     = 16'h0FFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [PC_W-1:0]     imem_addr,
  output logic                imem_rd_en,
  input  logic [15:0]         imem_data,
  input  logic                imem_valid,
  fetch_issue_unit_if.master  eu,
  output logic [PC_W-1:0]     pc,
`ifdef FIU_PERF_CNT_EN
  output logic [15:0]         issued_count,
  output logic [15:0]         stall_count,
`endif
  output logic                halted
);

  fiu_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [3:0]      op;
  logic            stall;
  logic            issue_valid;
  logic            transfer;

  assign op          = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign issue_valid = (state_q == S_ISSUE) && !stall;
  assign transfer    = issue_valid && eu.eu_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    // NOTE: hold values assigned up front so no path leaves a target
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_WAIT_MEM;
      S_WAIT_MEM: begin
        if (imem_valid) begin
          instr_d = imem_data;
          if (imem_data == HALT_WORD) begin
            state_d = S_HALTED;
          end else if (imem_data[OPCODE_MSB:OPCODE_LSB] == OP_NOP) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (transfer) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  hazard_tracker #(.HAZARD_CYCLES(HAZARD_CYCLES)) u_hazard (
    .clk      (clk),
    .reset    (reset),
    .transfer (transfer),
    .writes   (writes_reg(op)),
    .dest     (instr_q[DEST_MSB:DEST_LSB]),
    .reads_a  (reads_a(op)),
    .reads_b  (reads_b(op)),
    .src_a    (instr_q[SRCA_MSB:SRCA_LSB]),
    .src_b    (instr_q[SRCB_MSB:SRCB_LSB]),
    .stall    (stall)
  );

  assign imem_rd_en      = (state_q == S_FETCH);
  assign imem_addr       = pc_q;
  assign pc              = pc_q;
  assign halted          = (state_q == S_HALTED);
  assign eu.issue_valid  = issue_valid;
  assign eu.opcode       = op;
  assign eu.dest_reg     = instr_q[DEST_MSB:DEST_LSB];
  assign eu.opAAdr       = instr_q[SRCA_MSB:SRCA_LSB];
  assign eu.opBAdr       = instr_q[SRCB_MSB:SRCB_LSB];
  assign eu.storeDataAdr = instr_q[SDA_MSB:SDA_LSB];

`ifdef FIU_PERF_CNT_EN
  logic start_accept;
  assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_HALTED));

  // Saturating event counters, cleared whenever a run is (re)started.
  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      issued_count <= '0;
      stall_count  <= '0;
    end else begin
      if (transfer && (issued_count != 16'hFFFF))
        issued_count <= issued_count + 16'd1;
      if ((state_q == S_ISSUE) && stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Scoreboard bench for fetch_issue_unit: program walk fills the expected
// issue queue; a monitor checks issue timing, fields and pc every cycle.
module tb_fetch_issue_unit;

  localparam int          PC_W  = 2;
  localparam int          HAZ   = 3;
  localparam logic [15:0] HALT  = 16'h0FFF;
  localparam int          MEM_N = 1 << PC_W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd_en;
  logic [15:0]     imem_data = '0;
  logic            imem_valid = 1'b0;
  logic [PC_W-1:0] pc;
  logic            halted;
`ifdef FIU_PERF_CNT_EN
  logic [15:0]     issued_count;
  logic [15:0]     stall_count;
`endif

  fetch_issue_unit_if eu ();

  fetch_issue_unit #(.PC_W(PC_W), .HAZARD_CYCLES(HAZ), .HALT_WORD(HALT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .imem_addr    (imem_addr),
    .imem_rd_en   (imem_rd_en),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .eu           (eu),
    .pc           (pc),
`ifdef FIU_PERF_CNT_EN
    .issued_count (issued_count),
    .stall_count  (stall_count),
`endif
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    int          pc;
  } rec_t;

  rec_t        q[$];
  logic [15:0] mem [MEM_N];
  int          total = 0, bad = 0, cyc = 0;
  bit          live = 0, pending = 0, pc_chk = 0, last_w = 0, exp_halt = 0;
  int          issue_from = 0, last_xfer = -100, exp_pc = 0, exp_halt_pc = 0;
  logic [15:0] pend_w = '0;
  logic [2:0]  last_dest = '0;
  int          tb_issued = 0, tb_stalls = 0;
  int          lat_min = 1, lat_max = 1, ready_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register usage rules, straight from the instruction set description.
  function automatic bit m_writes(input logic [3:0] op);
    return op inside {[4'd1:4'd14]};
  endfunction
  function automatic bit m_reads_a(input logic [3:0] op);
    return (op inside {[4'd1:4'd13]}) || (op == 4'd15);
  endfunction
  function automatic bit m_reads_b(input logic [3:0] op);
    return op inside {[4'd1:4'd5]};
  endfunction
  function automatic bit depends(input logic [15:0] w);
    return (m_reads_a(w[15:12]) && (w[8:6] == last_dest)) ||
           (m_reads_b(w[15:12]) && (w[5:3] == last_dest));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    eu.eu_ready = ($urandom_range(99, 0) < ready_pct);
  end

  // Instruction memory with latency lat_min..lat_max cycles.
  initial begin : responder
    int          a;
    int          lat;
    logic [15:0] wd;
    forever begin
      @(negedge clk);
      if (imem_rd_en) begin
        a   = int'(imem_addr);
        lat = $urandom_range(lat_max, lat_min);
        repeat (lat) @(posedge clk);
        #1;
        wd         = mem[a];
        imem_valid = 1'b1;
        imem_data  = wd;
        if (live && (wd != HALT) && (wd[15:12] != 4'd0)) begin
          pending    = 1;
          issue_from = cyc + 1;
          pend_w     = wd;
        end
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_data  = 16'($urandom);
      end
    end
  end

  initial begin : monitor
    bit   exp_v;
    rec_t r;
    forever begin
      @(negedge clk);
      if (pc_chk) begin
        check("pc_after_transfer", pc, exp_pc);
        pc_chk = 0;
      end
      exp_v = pending && (cyc >= issue_from) &&
              !(last_w && depends(pend_w) && (cyc <= last_xfer + HAZ));
      if (pending && (cyc >= issue_from) && !exp_v) tb_stalls++;
      check("issue_valid", eu.issue_valid, exp_v);
      if (eu.issue_valid && eu.eu_ready) begin
        check("issue_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          r = q.pop_front();
          check("opcode", eu.opcode, r.w[15:12]);
          check("dest_reg", eu.dest_reg, r.w[11:9]);
          check("opAAdr", eu.opAAdr, r.w[8:6]);
          check("opBAdr", eu.opBAdr, r.w[5:3]);
          check("storeDataAdr", eu.storeDataAdr, r.w[3:0]);
          check("pc_at_issue", pc, r.pc);
          last_w    = m_writes(r.w[15:12]);
          last_dest = r.w[11:9];
          last_xfer = cyc;
          exp_pc    = (r.pc + 1) % MEM_N;
          pc_chk    = 1;
          tb_issued++;
        end
        pending = 0;
      end else if (eu.issue_valid && (q.size() != 0)) begin
        check("held_fields", {eu.opcode, eu.dest_reg, eu.opAAdr, eu.opBAdr, eu.storeDataAdr},
              {q[0].w[15:12], q[0].w[11:9], q[0].w[8:6], q[0].w[5:3], q[0].w[3:0]});
        check("held_pc", pc, q[0].pc);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural walk of the program: what gets issued, where it halts.
  task automatic walk(input int steps);
    int          p;
    logic [15:0] w;
    q.delete();
    exp_halt = 0;
    p = 0;
    for (int i = 0; i < steps; i++) begin
      w = mem[p];
      if (w == HALT) begin
        exp_halt    = 1;
        exp_halt_pc = p;
        break;
      end
      if (w[15:12] != 4'd0) q.push_back('{w: w, pc: p});
      p = (p + 1) % MEM_N;
    end
  endtask

  task automatic set_prog(input logic [15:0] w0, w1, w2, w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
  endtask

  task automatic load_and_start(input int steps);
    walk(steps);
    @(negedge clk);
    tb_issued = 0;
    tb_stalls = 0;
    start = 1'b1;
    live  = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("fetch_rd_en", imem_rd_en, 1);
    check("fetch_addr", imem_addr, 0);
  endtask

  task automatic finish_prog();
    int n = 0;
    while (((q.size() != 0) || (exp_halt && !halted)) && (n < 2000)) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("queue_drained", q.size(), 0);
    if (exp_halt) begin
      check("halted", halted, 1);
      check("halt_pc", pc, exp_halt_pc);
    end
`ifdef FIU_PERF_CNT_EN
    check("issued_count", issued_count, tb_issued);
    check("stall_count", stall_count, tb_stalls);
`endif
  endtask

  task automatic do_reset();
    live = 0;
    @(negedge clk);
    reset    = 1'b1;
    pending  = 0;
    q.delete();
    last_w    = 0;
    last_xfer = -100;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int n;
    eu.eu_ready = 1'b1;
    set_prog(HALT, HALT, HALT, HALT);
    repeat (3) @(negedge clk);
    check("reset_outputs", {imem_addr, imem_rd_en, eu.issue_valid, pc, halted, eu.opcode,
          eu.dest_reg, eu.opAAdr, eu.opBAdr, eu.storeDataAdr}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single ADD, then halt.
    set_prog(16'h1448, HALT, HALT, HALT);
    load_and_start(8);
    finish_prog();
    do_reset();

    // ADD d2 then INC reading r2: one hazard stall cycle.
    set_prog(16'h1448, 16'h6480, HALT, HALT);
    load_and_start(8);
    finish_prog();
`ifdef FIU_PERF_CNT_EN
    check("stall_count_add_inc", stall_count, 1);
`endif
    do_reset();

    // LOAD r1 then STORE reading r1.
    set_prog(16'hE20A, 16'hF045, HALT, HALT);
    load_and_start(8);
    finish_prog();
    do_reset();

    // eu_ready held low for four ISSUE cycles.
    set_prog(16'h1448, HALT, HALT, HALT);
    ready_pct = 0;
    load_and_start(8);
    n = 0;
    while (!eu.issue_valid && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("valid_before_ready", eu.issue_valid, 1);
    repeat (3) @(negedge clk);
    ready_pct = 100;
    @(negedge clk);
    check("transfer_on_ready", {eu.issue_valid, eu.eu_ready}, 2'b11);
    finish_prog();
    do_reset();

    // NOP then HALT, then restart from the halted state.
    set_prog(16'h0000, HALT, 16'h1448, 16'h1448);
    load_and_start(8);
    finish_prog();
    load_and_start(8);
    finish_prog();
    do_reset();

    // No NOP/HALT: pc wraps past the top of memory.
    for (int i = 0; i < MEM_N; i++) mem[i] = {4'($urandom_range(14, 1)), 12'($urandom)};
    load_and_start(10);
    finish_prog();
    do_reset();

    // Reset in WAIT_MEM with start also high; the late memory reply is ignored.
    set_prog(16'h1448, HALT, HALT, HALT);
    lat_min = 3;
    lat_max = 3;
    load_and_start(8);
    @(negedge clk);
    live  = 0;
    q.delete();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("reset_mid_fetch_outputs", {imem_addr, imem_rd_en, eu.issue_valid, pc, halted,
          eu.opcode, eu.dest_reg, eu.opAAdr, eu.opBAdr, eu.storeDataAdr}, 0);
    @(negedge clk);
    check("reset_beats_start", imem_rd_en, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_late_valid", {imem_rd_en, halted}, 0);
    end
    last_w    = 0;
    last_xfer = -100;
    lat_min   = 1;
    lat_max   = 1;

    // Randomized programs, memory latency and eu back-pressure.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < MEM_N; i++) begin
        mem[i] = 16'($urandom);
        if ($urandom_range(9, 0) == 0) mem[i] = HALT;
        else if ($urandom_range(9, 0) == 0) mem[i][15:12] = 4'd0;
        mem[i][11:9] = 3'($urandom_range(3, 0));
        mem[i][8:6]  = 3'($urandom_range(3, 0));
        mem[i][5:3]  = 3'($urandom_range(3, 0));
      end
      lat_max   = $urandom_range(3, 1);
      ready_pct = $urandom_range(100, 30);
      load_and_start(14);
      finish_prog();
      do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
